// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl : MEM-stage data-memory access unit of the 5-stage RV32 pipeline.
//
// Turns the load/store sitting in the EX/MEM register into a transaction on a
// req/gnt/rvalid data bus with variable latency. Loads are returned aligned and
// sign/zero-extended on RD_data. StallM holds the pipeline until the access
// completes.
//
// Ports
//   clk, clr          clock, synchronous active-high reset
//   MemWriteM         store in MEM stage (wins over MemReadM)
//   MemReadM          load in MEM stage
//   Funct3M           RV32I load/store funct3 (size / sign)
//   ALUResultM        byte address
//   WriteDataM        store data (low bytes significant)
//   RD_data           formatted load result
//   StallM            hold pipeline while the access is outstanding
//   MisalignM         misaligned access, no bus activity
//   BusErrM           one-cycle pulse after a bus timeout
//   mem_req/we/addr/wdata/be   bus request side
//   mem_gnt/rvalid/rdata       bus response side
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD_data,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RD, DONE} state_t;

    // Last counter value before the limit is reached; only meaningful when
    // the timeout is enabled.
    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

    state_t      state_reg;
    logic [31:0] capture_reg;
    logic [31:0] cnt_reg;
    logic        bus_err_reg;
    logic [1:0]  off_reg;
    logic [2:0]  f3_reg;

    logic access;
    logic is_write;
    logic aligned;
    logic misalign;
    logic timeout_hit;

    assign access   = MemWriteM | MemReadM;
    assign is_write = MemWriteM;

    always_comb begin
        case (Funct3M[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ALUResultM[0];
            default: aligned = (ALUResultM[1:0] == 2'b00);
        endcase
    end

    assign misalign    = access & ~aligned;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);

    // Handshake outputs depend on the live grant so a write granted in the
    // request cycle costs no stall.
    always_comb begin
        mem_req   = 1'b0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        if (!clr) begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
                            MisalignM = 1'b1;
                        end else begin
                            mem_req = 1'b1;
                            StallM  = ~(is_write & mem_gnt);
                        end
                    end
                end
                WAIT_GNT: begin
                    mem_req = 1'b1;
                    // A write that is granted or abandoned releases the pipe now.
                    StallM  = ~(is_write & (mem_gnt | timeout_hit));
                end
                WAIT_RD: StallM = 1'b1;
                default: StallM = 1'b0;
            endcase
        end
    end

    // Bus request fields come straight from the frozen MEM-stage inputs.
    assign mem_we   = MemWriteM;
    assign mem_addr = {ALUResultM[31:2], 2'b00};

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << ALUResultM[1:0];
                    mem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << ALUResultM[1:0];
                    mem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Lane select and extension of a returned word.
    function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            capture_reg <= 32'd0;
            cnt_reg     <= 32'd0;
            bus_err_reg <= 1'b0;
            off_reg     <= 2'd0;
            f3_reg      <= 3'd0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 32'd0;
                    if (access && !misalign) begin
                        if (mem_gnt) begin
                            off_reg   <= ALUResultM[1:0];
                            f3_reg    <= Funct3M;
                            state_reg <= is_write ? IDLE : WAIT_RD;
                        end else begin
                            state_reg <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    cnt_reg <= cnt_reg + 32'd1;
                    if (mem_gnt) begin
                        off_reg   <= ALUResultM[1:0];
                        f3_reg    <= Funct3M;
                        state_reg <= is_write ? IDLE : WAIT_RD;
                    end else if (timeout_hit) begin
                        bus_err_reg <= 1'b1;
                        capture_reg <= 32'd0;
                        state_reg   <= is_write ? IDLE : DONE;
                    end
                end
                WAIT_RD: begin
                    cnt_reg <= cnt_reg + 32'd1;
                    // Data arriving in the limit cycle is still accepted.
                    if (mem_rvalid) begin
                        capture_reg <= fmt_load(mem_rdata, off_reg, f3_reg);
                        state_reg   <= DONE;
                    end else if (timeout_hit) begin
                        bus_err_reg <= 1'b1;
                        capture_reg <= 32'd0;
                        state_reg   <= DONE;
                    end
                end
                default: begin
                    cnt_reg   <= 32'd0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign RD_data = MisalignM ? 32'd0 : capture_reg;
    assign BusErrM = bus_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl : scoreboard bench for dmem_ctrl (TIMEOUT_CYCLES = 4).
// Stimulus pushes expected bus requests and expected instruction completions;
// a monitor pops and compares on each grant and each cycle an access leaves
// the MEM stage (access present, StallM low).
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemWriteM, MemReadM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] RD_data;
    logic        StallM, MisalignM, BusErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RD_data    (RD_data),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        int          stalls;
        bit          mis;
        bit          is_load;
        logic [31:0] rd;
        bit          berr;
    } comp_t;

    bus_t  bus_q[$];
    comp_t comp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        int    stall_cnt;
        bus_t  b;
        comp_t c;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (clr) begin
                stall_cnt = 0;
            end else begin
                if (mem_req && mem_gnt) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_grant", {31'd0, mem_req}, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_we",    {31'd0, mem_we}, {31'd0, b.we});
                        chk("bus_addr",  mem_addr, b.addr);
                        chk("bus_be",    {28'd0, mem_be}, {28'd0, b.be});
                        chk("bus_wdata", mem_wdata, b.wdata);
                    end
                end
                if (MemWriteM || MemReadM) begin
                    if (StallM) begin
                        stall_cnt++;
                    end else begin
                        if (comp_q.size() == 0) begin
                            chk("unexpected_completion", 32'd1, 32'd0);
                        end else begin
                            c = comp_q.pop_front();
                            chk("stall_cycles", stall_cnt, c.stalls);
                            chk("misalign", {31'd0, MisalignM}, {31'd0, c.mis});
                            chk("bus_err", {31'd0, BusErrM}, {31'd0, c.berr});
                            if (c.mis)     chk("misalign_req", {31'd0, mem_req}, 32'd0);
                            if (c.is_load) chk("rd_data", RD_data, c.rd);
                        end
                        stall_cnt = 0;
                    end
                end
            end
        end
    end

    // One MEM-stage instruction; gnt/rvalid are driven at the given cycle
    // offsets (-1 = never). Returns once the instruction has left MEM.
    task automatic access(input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_at, input int rv_at, input logic [31:0] rdata,
                          input bit exp_bus, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int exp_stalls,
                          input bit exp_mis, input logic [31:0] exp_rd, input bit exp_berr);
        bus_t  b;
        comp_t c;
        bit    done;
        if (exp_bus) begin
            b.we = wr; b.addr = {addr[31:2], 2'b00}; b.be = exp_be; b.wdata = exp_wdata;
            bus_q.push_back(b);
        end
        c.stalls = exp_stalls; c.mis = exp_mis; c.is_load = rd & ~wr;
        c.rd = exp_rd; c.berr = exp_berr;
        comp_q.push_back(c);
        $display("txn %s f3=%0d addr=0x%08h wdata=0x%08h gnt@%0d rvalid@%0d rdata=0x%08h",
                 wr ? "ST" : "LD", f3, addr, wd, gnt_at, rv_at, rdata);
        MemWriteM = wr; MemReadM = rd; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; mem_rdata = rdata;
        done = 1'b0;
        for (int k = 0; k < 64; k++) begin
            mem_gnt    = (k == gnt_at);
            mem_rvalid = (k == rv_at);
            @(negedge clk);
            done = !StallM;
            @(posedge clk);
            #2;
            if (done) break;
        end
        if (!done) chk("access_cycle_budget", 32'd0, 32'd1);
        MemWriteM = 1'b0; MemReadM = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        bus_t b;
        clr = 1'b1;
        MemWriteM = 1'b0; MemReadM = 1'b1; Funct3M = 3'b010;
        ALUResultM = 32'h6; WriteDataM = 32'd0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;

        // Reset: outputs quiet even with a misaligned load and a grant present.
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_stall",     {31'd0, StallM},    32'd0);
        chk("rst_misalign",  {31'd0, MisalignM}, 32'd0);
        chk("rst_bus_err",   {31'd0, BusErrM},   32'd0);
        chk("rst_rd_data",   RD_data,            32'd0);
        @(posedge clk);
        #2;
        MemReadM = 1'b0; mem_gnt = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #2;

        // wr rd f3 addr wdata gnt rv rdata | bus be wdata stalls mis rd berr
        access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, -1, 32'h0,         1, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0,        0);
        access(0, 1, 3'b000, 32'h203, 32'h0,        0,  2, 32'h80FF_0000, 1, 4'b1111, 32'h0,        3, 0, 32'hFFFFFF80, 0);
        access(0, 1, 3'b100, 32'h203, 32'h0,        0,  2, 32'h80FF_0000, 1, 4'b1111, 32'h0,        3, 0, 32'h00000080, 0);
        access(1, 0, 3'b001, 32'h002, 32'h1234ABCD, 3, -1, 32'h0,         1, 4'b1100, 32'hABCDABCD, 3, 0, 32'h0,        0);
        access(0, 1, 3'b010, 32'h006, 32'h0,        0, -1, 32'h0,         0, 4'b1111, 32'h0,        0, 1, 32'h0,        0);
        access(1, 0, 3'b001, 32'h001, 32'h0000FFFF, 0, -1, 32'h0,         0, 4'b0000, 32'h0,        0, 1, 32'h0,        0);
        access(0, 1, 3'b001, 32'h002, 32'h0,        1,  3, 32'h8001_1234, 1, 4'b1111, 32'h0,        4, 0, 32'hFFFF8001, 0);
        access(0, 1, 3'b101, 32'h000, 32'h0,        0,  1, 32'h8001_F234, 1, 4'b1111, 32'h0,        2, 0, 32'h0000F234, 0);
        access(1, 0, 3'b000, 32'h103, 32'h000000A5, 0, -1, 32'h0,         1, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0,        0);
        access(1, 0, 3'b010, 32'h00C, 32'h0BADF00D, 1, -1, 32'h0,         1, 4'b1111, 32'h0BADF00D, 1, 0, 32'h0,        0);
        access(0, 1, 3'b010, 32'h004, 32'h0,        2,  3, 32'hCAFEF00D, 1, 4'b1111, 32'h0,        4, 0, 32'hCAFEF00D, 0);
        access(0, 1, 3'b000, 32'h001, 32'h0,        0,  1, 32'h0000_7F00, 1, 4'b1111, 32'h0,        2, 0, 32'h0000007F, 0);
        access(0, 1, 3'b110, 32'h008, 32'h0,        0,  1, 32'h1234_5678, 1, 4'b1111, 32'h0,        2, 0, 32'h12345678, 0);
        // Timeout: granted load, no rvalid; 4 WAIT_RD cycles then DONE with error.
        access(0, 1, 3'b010, 32'h010, 32'h0,        0, -1, 32'h0,         1, 4'b1111, 32'h0,        5, 0, 32'h0,        1);

        // Stray rvalid while idle is ignored; error pulse lasted one cycle.
        $display("txn stray rvalid rdata=0x00000055");
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("berr_one_cycle", {31'd0, BusErrM}, 32'd0);
        chk("stray_rd_now",   RD_data,          32'd0);
        @(posedge clk);
        #2;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_rd_after", RD_data, 32'd0);
        @(posedge clk);
        #2;

        // Reset in WAIT_RD abandons the load; a late rvalid must not land.
        $display("txn LD f3=2 addr=0x00000020 aborted by clr");
        b.we = 1'b0; b.addr = 32'h20; b.be = 4'b1111; b.wdata = 32'h0;
        bus_q.push_back(b);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h20; WriteDataM = 32'h0;
        mem_gnt = 1'b1;
        @(posedge clk);
        #2;
        mem_gnt = 1'b0;
        @(posedge clk);
        #2;
        clr = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        chk("clr_mem_req", {31'd0, mem_req}, 32'd0);
        chk("clr_stall",   {31'd0, StallM},  32'd0);
        @(posedge clk);
        #2;
        clr = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        chk("post_clr_mem_req", {31'd0, mem_req}, 32'd0);
        chk("post_clr_stall",   {31'd0, StallM},  32'd0);
        chk("post_clr_rd",      RD_data,          32'd0);
        @(posedge clk);
        #2;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_rd", RD_data, 32'd0);
        @(posedge clk);
        #2;

        // Controller usable again after the abort.
        access(0, 1, 3'b100, 32'h003, 32'h0,        0,  1, 32'hFE00_0000, 1, 4'b1111, 32'h0,        2, 0, 32'h000000FE, 0);

        @(posedge clk);
        #2;
        chk("bus_q_drained",  bus_q.size(),  32'd0);
        chk("comp_q_drained", comp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
